// File: rtl/font_rom_arbiter_pkg.sv
// font_rom_pkg: shared font ROM types and default geometry, also used by the VGA controller
package font_rom_pkg;
    localparam int FONT_ADDR_SIZE = 7;
    localparam int FONT_FNT_W = 4;
    typedef enum logic {ARB, STARVE} arb_state_t;
    typedef enum logic [1:0] {OWN_NONE, OWN_P0, OWN_P1} owner_t;
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction
endpackage

// File: rtl/font_rom_arbiter_if.sv
// font_rom_arbiter_if: client request/response channels plus the ROM macro pins
interface font_rom_arbiter_if #(
    parameter int ADDR_SIZE = 7,
    parameter int FNT_W = 4
);
    logic                 req0_valid;
    logic [ADDR_SIZE-1:0] req0_addr;
    logic                 req0_ready;
    logic                 rsp0_valid;
    logic [FNT_W-1:0]     rsp0_data;
    logic                 req1_valid;
    logic [ADDR_SIZE-1:0] req1_addr;
    logic                 req1_ready;
    logic                 rsp1_valid;
    logic [FNT_W-1:0]     rsp1_data;
    logic                 rom_clk;
    logic [ADDR_SIZE-1:0] rom_addr;
    logic [FNT_W-1:0]     rom_q;
    modport master (
        output req0_valid, req0_addr, req1_valid, req1_addr, rom_q,
        input  req0_ready, rsp0_valid, rsp0_data, req1_ready, rsp1_valid, rsp1_data, rom_clk, rom_addr
    );
    modport slave (
        input  req0_valid, req0_addr, req1_valid, req1_addr, rom_q,
        output req0_ready, rsp0_valid, rsp0_data, req1_ready, rsp1_valid, rsp1_data, rom_clk, rom_addr
    );
endinterface

// File: rtl/font_rom_arbiter_rom_owner_pipe.sv
// rom_owner_pipe: DEPTH-stage shift register tracking which client owns each in-flight ROM read
module rom_owner_pipe
    import font_rom_pkg::*;
#(
    parameter int DEPTH = 1
) (
    input  logic   clk,
    input  logic   rst_n,
    input  owner_t tag_i,
    output owner_t tag_o
);
    owner_t stage_q [DEPTH];
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) stage_q[i] <= OWN_NONE;
        end else begin
            stage_q[0] <= tag_i;
            for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
        end
    end
    assign tag_o = stage_q[DEPTH-1];
endmodule

// File: rtl/font_rom_arbiter.sv
// font_rom_arbiter: shares one synchronous font ROM between the VGA renderer (port 0) and a background client (port 1).
// Define FONT_ROM_ARB_STATS_EN to add saturating grant/starve statistics counters.
module font_rom_arbiter
    import font_rom_pkg::*;
#(
    parameter int ADDR_SIZE = FONT_ADDR_SIZE,
    parameter int FNT_W = FONT_FNT_W,
    parameter int ROM_LAT = 1,
    parameter int MAX_WAIT = 8
) (
    input logic clk,
    input logic rst_n,
    input logic blank,
    font_rom_arbiter_if.slave bus
`ifdef FONT_ROM_ARB_STATS_EN
    ,
    input  logic        stat_clr,
    output logic [15:0] stat_grant0,
    output logic [15:0] stat_grant1,
    output logic [15:0] stat_starve
`endif
);
    arb_state_t           state_q, state_d;
    logic [7:0]           wait_q, wait_d;
    logic [ADDR_SIZE-1:0] rom_addr_q, rom_addr_d;
    logic                 rsp0_valid_q, rsp0_valid_d, rsp1_valid_q, rsp1_valid_d;
    logic [FNT_W-1:0]     rsp0_data_q, rsp0_data_d, rsp1_data_q, rsp1_data_d;
    logic                 gnt0, gnt1, xfer0, xfer1, denied, starve_entry;
    owner_t               tag_in, tag_out;
    always_comb begin
        gnt0 = state_q == ARB && (blank ? bus.req0_valid && !bus.req1_valid : bus.req0_valid);
        gnt1 = state_q == STARVE || (blank ? bus.req1_valid : bus.req1_valid && !bus.req0_valid);
        xfer0 = rst_n && gnt0 && bus.req0_valid;
        xfer1 = rst_n && gnt1 && bus.req1_valid;
        denied = bus.req1_valid && !gnt1;
        wait_d = denied ? sat_inc8(wait_q) : 8'd0;
        // >= keeps the forced grant reachable once the counter has saturated
        starve_entry = state_q == ARB && denied && wait_q >= 8'(MAX_WAIT - 1);
        state_d = starve_entry ? STARVE : ARB;
        rom_addr_d = xfer1 ? bus.req1_addr : xfer0 ? bus.req0_addr : rom_addr_q;
        tag_in = xfer0 ? OWN_P0 : xfer1 ? OWN_P1 : OWN_NONE;
        rsp0_valid_d = tag_out == OWN_P0;
        rsp1_valid_d = tag_out == OWN_P1;
        rsp0_data_d = rsp0_valid_d ? bus.rom_q : rsp0_data_q;
        rsp1_data_d = rsp1_valid_d ? bus.rom_q : rsp1_data_q;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ARB;
            wait_q <= 8'd0;
            rom_addr_q <= '0;
            rsp0_valid_q <= 1'b0;
            rsp1_valid_q <= 1'b0;
            rsp0_data_q <= '0;
            rsp1_data_q <= '0;
        end else begin
            state_q <= state_d;
            wait_q <= wait_d;
            rom_addr_q <= rom_addr_d;
            rsp0_valid_q <= rsp0_valid_d;
            rsp1_valid_q <= rsp1_valid_d;
            rsp0_data_q <= rsp0_data_d;
            rsp1_data_q <= rsp1_data_d;
        end
    end
    rom_owner_pipe #(.DEPTH(ROM_LAT)) u_pipe (
        .clk  (clk),
        .rst_n(rst_n),
        .tag_i(tag_in),
        .tag_o(tag_out)
    );
    assign bus.req0_ready = rst_n && gnt0;
    assign bus.req1_ready = rst_n && gnt1;
    assign bus.rsp0_valid = rsp0_valid_q;
    assign bus.rsp1_valid = rsp1_valid_q;
    assign bus.rsp0_data = rsp0_data_q;
    assign bus.rsp1_data = rsp1_data_q;
    assign bus.rom_clk = clk;
    assign bus.rom_addr = rom_addr_q;
`ifdef FONT_ROM_ARB_STATS_EN
    logic [15:0] grant0_q, grant1_q, starve_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant0_q <= 16'd0;
            grant1_q <= 16'd0;
            starve_q <= 16'd0;
        end else if (stat_clr) begin
            grant0_q <= 16'd0;
            grant1_q <= 16'd0;
            starve_q <= 16'd0;
        end else begin
            grant0_q <= grant0_q + 16'(xfer0 && grant0_q != 16'hFFFF);
            grant1_q <= grant1_q + 16'(xfer1 && grant1_q != 16'hFFFF);
            starve_q <= starve_q + 16'(starve_entry && starve_q != 16'hFFFF);
        end
    end
    assign stat_grant0 = grant0_q;
    assign stat_grant1 = grant1_q;
    assign stat_starve = starve_q;
`endif
endmodule

// File: tb/tb_font_rom_arbiter.sv
// tb_font_rom_arbiter: directed checks on two arbiters (ROM_LAT=1/MAX_WAIT=8 and ROM_LAT=2/MAX_WAIT=255) sharing one stimulus
module tb_font_rom_arbiter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic blank = 1'b0;
    logic r0v = 1'b0, r1v = 1'b0;
    logic [6:0] r0a = 7'd0, r1a = 7'd0;
    int n_chk = 0, n_pass = 0;
    always #5 clk = ~clk;
    font_rom_arbiter_if #(.ADDR_SIZE(7), .FNT_W(4)) ifa ();
    font_rom_arbiter_if #(.ADDR_SIZE(7), .FNT_W(4)) ifb ();
    // ROM contents: word = ~addr[3:0] + addr[6:4], so 0x05->A, 0x10->0, 0x20->1, 0x30->2
    function automatic logic [3:0] mem(input logic [6:0] a);
        return (a[3:0] ^ 4'hF) + {1'b0, a[6:4]};
    endfunction
    logic [3:0] qb;
    always @(posedge clk) qb <= mem(ifb.rom_addr);
    assign ifa.rom_q = mem(ifa.rom_addr);
    assign ifb.rom_q = qb;
    assign ifa.req0_valid = r0v;
    assign ifa.req0_addr = r0a;
    assign ifa.req1_valid = r1v;
    assign ifa.req1_addr = r1a;
    assign ifb.req0_valid = r0v;
    assign ifb.req0_addr = r0a;
    assign ifb.req1_valid = r1v;
    assign ifb.req1_addr = r1a;
`ifdef FONT_ROM_ARB_STATS_EN
    logic [15:0] sg0a, sg1a, ssa, sg0b, sg1b, ssb;
    font_rom_arbiter #(.ROM_LAT(1), .MAX_WAIT(8)) dut_a (
        .clk(clk), .rst_n(rst_n), .blank(blank), .bus(ifa),
        .stat_clr(1'b0), .stat_grant0(sg0a), .stat_grant1(sg1a), .stat_starve(ssa));
    font_rom_arbiter #(.ROM_LAT(2), .MAX_WAIT(255)) dut_b (
        .clk(clk), .rst_n(rst_n), .blank(blank), .bus(ifb),
        .stat_clr(1'b0), .stat_grant0(sg0b), .stat_grant1(sg1b), .stat_starve(ssb));
`else
    font_rom_arbiter #(.ROM_LAT(1), .MAX_WAIT(8)) dut_a (
        .clk(clk), .rst_n(rst_n), .blank(blank), .bus(ifa));
    font_rom_arbiter #(.ROM_LAT(2), .MAX_WAIT(255)) dut_b (
        .clk(clk), .rst_n(rst_n), .blank(blank), .bus(ifb));
`endif
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    initial begin
        int first;
        int grants;
        r0v = 1'b1;
        #1;
        check("rst ready0", 32'(ifa.req0_ready), 0);
        check("rst rom_addr", 32'(ifa.rom_addr), 0);
        check("rst rsp0_valid", 32'(ifa.rsp0_valid), 0);
        check("rst rsp1_data", 32'(ifa.rsp1_data), 0);
        repeat (2) tick();
        rst_n = 1'b1;
        r0v = 1'b0;
        tick();
        // single port 0 read, ROM_LAT=1
        r0v = 1'b1;
        r0a = 7'h05;
        #1;
        check("p0 ready", 32'(ifa.req0_ready), 1);
        tick();
        r0v = 1'b0;
        check("p0 rom_addr", 32'(ifa.rom_addr), 32'h05);
        tick();
        check("p0 rsp_valid", 32'(ifa.rsp0_valid), 1);
        check("p0 rsp_data", 32'(ifa.rsp0_data), 32'hA);
        check("p0 rsp1 quiet", 32'(ifa.rsp1_valid), 0);
        tick();
        check("p0 rsp_valid drop", 32'(ifa.rsp0_valid), 0);
        check("p0 rsp_data hold", 32'(ifa.rsp0_data), 32'hA);
        // contention in active video: 8 port 0 grants then a forced port 1 grant
        blank = 1'b0;
        r0v = 1'b1;
        r1v = 1'b1;
        r0a = 7'h10;
        r1a = 7'h20;
        for (int c = 0; c < 18; c++) begin
            #1;
            check($sformatf("contend ready1 c%0d", c), 32'(ifa.req1_ready), 32'(c % 9 == 8));
            check($sformatf("contend ready0 c%0d", c), 32'(ifa.req0_ready), 32'(c % 9 != 8));
            tick();
        end
        r0v = 1'b0;
        r1v = 1'b0;
`ifdef FONT_ROM_ARB_STATS_EN
        check("stat_starve", 32'(ssa), 2);
        check("stat_grant1", 32'(sg1a), 2);
`endif
        repeat (2) tick();
        // blanking: port 1 wins every cycle and its wait counter never builds up
        blank = 1'b1;
        r0v = 1'b1;
        r1v = 1'b1;
        for (int c = 0; c < 5; c++) begin
            #1;
            check($sformatf("blank ready1 c%0d", c), 32'(ifa.req1_ready), 1);
            check($sformatf("blank ready0 c%0d", c), 32'(ifa.req0_ready), 0);
            tick();
        end
        blank = 1'b0;
        for (int c = 0; c < 9; c++) begin
            #1;
            check($sformatf("post-blank ready1 c%0d", c), 32'(ifa.req1_ready), 32'(c == 8));
            tick();
        end
        r0v = 1'b0;
        r1v = 1'b0;
        repeat (2) tick();
        // alternating grants on the ROM_LAT=2 instance
        r0v = 1'b1;
        r0a = 7'h10;
        #1;
        check("alt g0 ready0", 32'(ifb.req0_ready), 1);
        tick();
        r0v = 1'b0;
        r1v = 1'b1;
        r1a = 7'h20;
        #1;
        check("alt g1 ready1", 32'(ifb.req1_ready), 1);
        tick();
        r1v = 1'b0;
        r0v = 1'b1;
        r0a = 7'h30;
        #1;
        check("alt g2 ready0", 32'(ifb.req0_ready), 1);
        tick();
        r0v = 1'b0;
        check("alt r0 valid", 32'(ifb.rsp0_valid), 1);
        check("alt r0 data", 32'(ifb.rsp0_data), 32'h0);
        check("alt r0 rsp1 quiet", 32'(ifb.rsp1_valid), 0);
        tick();
        check("alt r1 valid", 32'(ifb.rsp1_valid), 1);
        check("alt r1 data", 32'(ifb.rsp1_data), 32'h1);
        check("alt r1 rsp0 quiet", 32'(ifb.rsp0_valid), 0);
        tick();
        check("alt r2 valid", 32'(ifb.rsp0_valid), 1);
        check("alt r2 data", 32'(ifb.rsp0_data), 32'h2);
        tick();
        // reset with a port 1 read in flight
        blank = 1'b1;
        r1v = 1'b1;
        r1a = 7'h20;
        #1;
        check("mid ready1", 32'(ifa.req1_ready), 1);
        tick();
        r1v = 1'b0;
        r0v = 1'b1;
        rst_n = 1'b0;
        #1;
        check("mid rom_addr", 32'(ifa.rom_addr), 0);
        check("mid rsp1_valid", 32'(ifa.rsp1_valid), 0);
        check("mid rsp1_data", 32'(ifa.rsp1_data), 0);
        check("mid ready0", 32'(ifa.req0_ready), 0);
        tick();
        r0v = 1'b0;
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick();
            check($sformatf("after rst rsp1 c%0d", c), 32'(ifa.rsp1_valid), 0);
        end
        // long starvation on MAX_WAIT=255: forced grant still arrives
        blank = 1'b0;
        r0v = 1'b1;
        r1v = 1'b1;
        first = -1;
        grants = 0;
        for (int c = 0; c < 300; c++) begin
            #1;
            if (ifb.req1_ready) begin
                grants++;
                if (first < 0) first = c;
            end
            tick();
        end
        r0v = 1'b0;
        r1v = 1'b0;
        check("starve first grant", 32'(first), 255);
        check("starve grant count", 32'(grants), 1);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/font_rom_arbiter.md
Name: font_rom_arbiter

Overview:
- Shares the single synchronous font ROM between two requesters.
  - Port 0: text/VGA renderer. Latency-critical, highest priority during active video.
  - Port 1: background client, e.g. game-logic glyph lookup or a debug/overlay reader.
- Sits between the ROM macro (address, q, clock) and both clients.
- Issues at most one ROM read per clock and returns each q word to the client that issued it, after a fixed latency.

Parameters:
- ADDR_SIZE, 7, width of the ROM address bus.
- FNT_W, 4, ROM data width (one glyph line).
- ROM_LAT, 1, clocks from address register to valid q; legal range 1..3.
- MAX_WAIT, 8, consecutive denied cycles on port 1 before a forced grant; legal range 1..255.

Ports:
- clk  in  1  system clock; the ROM also runs on clk.
- rst_n  in  1  asynchronous active-low reset.
- blank  in  1  high while the VGA counters are outside the visible area.
- req0_valid  in  1  port 0 read request.
- req0_addr  in  ADDR_SIZE  port 0 address.
- req0_ready  out  1  port 0 request accepted this cycle.
- rsp0_valid  out  1  port 0 data valid.
- rsp0_data  out  FNT_W  port 0 data.
- req1_valid  in  1  port 1 read request.
- req1_addr  in  ADDR_SIZE  port 1 address.
- req1_ready  out  1  port 1 request accepted this cycle.
- rsp1_valid  out  1  port 1 data valid.
- rsp1_data  out  FNT_W  port 1 data.
- rom_clk  out  1  equals clk.
- rom_addr  out  ADDR_SIZE  registered ROM address.
- rom_q  in  FNT_W  ROM read data.

Behaviour:
- Reset (async, rst_n=0) clears all outputs and state:
  - rom_addr=0; rsp0/rsp1 valid=0, data=0.
  - Wait counter=0, FSM=ARB, owner pipeline all INVALID.
  - ready outputs are combinational and are 0 while rst_n=0.
- Handshake: a request transfers when valid && ready in the same cycle.
  - A requester holds valid and addr stable until accepted.
  - At most one of req0_ready/req1_ready is high per cycle.
- Transfer on clock edge N:
  - rom_addr <= granted addr.
  - Owner tag (P0/P1) enters stage 0 of a ROM_LAT-deep owner pipeline.
  - At edge N+ROM_LAT the tag exits the pipeline; on that edge rspX_data <= rom_q and rspX_valid <= 1 for one cycle.
  - Total request-accept to rsp_valid = ROM_LAT+1 clocks.
- Back-to-back grants sustain one read per cycle. Responses return in issue order; no response backpressure.
- rspX_data holds its last value while rspX_valid=0.
- FSM states:
  - ARB:
    - If blank=0: port 0 wins when req0_valid; else port 1 wins when req1_valid.
    - If blank=1: port 1 wins when req1_valid; else port 0.
  - STARVE: single-cycle state.
    - req1_ready=1, req0_ready=0 regardless of blank.
    - Always returns to ARB next cycle.
- Wait counter (8 bit):
  - +1 each cycle with req1_valid && !req1_ready.
  - Cleared on port 1 transfer or req1_valid=0.
  - Saturates at 255.
  - When counter reaches MAX_WAIT-1 while still denied, FSM enters STARVE next cycle.
  - MAX_WAIT=1 means port 1 wins every other cycle under contention.
- Simultaneous req0 and req1 with blank=0 in ARB: port 0 granted, counter increments.
- Idle (neither valid): rom_addr holds; no tag issued.
- Response and new grant on the same edge are independent: pipeline shifts and loads together.
- Reset mid-flight: in-flight tags are discarded; no response is emitted after rst_n deasserts.

Optional Feature:
- Macro FONT_ROM_ARB_STATS_EN.
- Defined:
  - Adds outputs stat_grant0 [15:0], stat_grant1 [15:0], stat_starve [15:0], stat_clr (input, 1).
  - Counts transfers per port and STARVE entries.
  - Counters saturate at 0xFFFF; stat_clr synchronously zeroes them; reset zeroes them.
- Undefined: these ports and counters do not exist; behaviour is otherwise identical.

Decomposition:
- Package font_rom_pkg:
  - typedef enum {ARB, STARVE} arb_state_t.
  - typedef enum logic [1:0] {OWN_NONE, OWN_P0, OWN_P1} owner_t.
  - Default ADDR_SIZE/FNT_W constants, shared with the VGA controller.
- Sub-module rom_owner_pipe (ROM_LAT-deep owner_t shift register with async reset) is natural and reusable for other shared ROMs.

Test Plan:
- Reset, then single port 0 read of addr 0x05 with ROM_LAT=1 and ROM word 0xA:
  - req0_ready=1 at cycle 0.
  - rom_addr=0x05 after edge 1.
  - rsp0_valid=1, rsp0_data=0xA after edge 2; rsp1_valid stays 0.
- blank=0, both ports valid continuously, MAX_WAIT=8:
  - port 0 granted 8 consecutive cycles.
  - port 1 granted on the 9th; pattern repeats.
  - stat_starve increments once per 9 cycles when the macro is defined.
- blank=1, both valid: port 1 granted every cycle; port 0 ready=0; wait counter stays 0.
- Alternating grants P0 0x10, P1 0x20, P0 0x30 on consecutive cycles with ROM_LAT=2:
  - rsp0, rsp1, rsp0 valid on consecutive cycles.
  - Each carries the ROM word for its own address.
- rst_n pulled low one cycle after a port 1 grant:
  - all outputs 0 immediately.
  - after release, rsp1_valid never asserts without a new request.
- Port 1 valid alone for 300 cycles with no grant possible (req0_valid=1, blank=0, MAX_WAIT=255): counter saturates at 255 and a STARVE grant still occurs.
